// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction memory answering refill requests after a fixed LATENCY.
// Optional feature macro IMEM_ADDR_CHECK_EN: out-of-range addresses return ERR_DATA with mem_err.
module imem_responder #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           MEM_WORDS  = 1024,
   parameter int unsigned           LATENCY    = 4,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_req,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_ready,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  busy,
   output logic                  mem_err
);

   localparam int unsigned IDX_BITS = $clog2(MEM_WORDS);
   localparam int unsigned CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e                state_q;
   logic [CNT_BITS-1:0]   cnt_q;
   logic [IDX_BITS-1:0]   idx_q;
   logic                  oor_q;
   logic [DATA_WIDTH-1:0] mem_data_q;
   logic                  mem_ready_q;
   logic                  mem_err_q;
   logic                  busy_q;

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic [IDX_BITS-1:0]   req_idx;
   logic [IDX_BITS-1:0]   load_idx;
   logic                  req_oor;
   logic                  unused_addr_bits;

   assign req_idx  = mem_addr[IDX_BITS+1:2];
   assign load_idx = load_addr[IDX_BITS+1:2];

`ifdef IMEM_ADDR_CHECK_EN
   assign req_oor = (mem_addr >> (IDX_BITS + 2)) != '0;
`else
   assign req_oor = 1'b0;
`endif

   // Byte offsets and (without the address check) upper bits are deliberately ignored.
   assign unused_addr_bits = ^{mem_addr[1:0], mem_addr[ADDR_WIDTH-1:IDX_BITS+2],
                               load_addr[1:0], load_addr[ADDR_WIDTH-1:IDX_BITS+2]};

   // Storage has no reset so program words survive rst; loads are blocked while rst is high.
   always_ff @(posedge clk) begin
      if (!rst && load_en) begin
         mem_q[load_idx] <= load_data;
      end
   end

   // Request FSM; the response read uses pre-edge storage, so a same-edge load returns the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         oor_q       <= 1'b0;
         mem_data_q  <= '0;
         mem_ready_q <= 1'b0;
         mem_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mem_req) begin
                  idx_q  <= req_idx;
                  oor_q  <= req_oor;
                  busy_q <= 1'b1;
                  if (LATENCY == 1) begin
                     state_q     <= ST_RESP;
                     mem_ready_q <= 1'b1;
                     mem_err_q   <= req_oor;
                     mem_data_q  <= req_oor ? ERR_DATA : mem_q[req_idx];
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= CNT_BITS'(LATENCY - 1);
                  end
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - CNT_BITS'(1);
               if (cnt_q == CNT_BITS'(1)) begin
                  state_q     <= ST_RESP;
                  mem_ready_q <= 1'b1;
                  mem_err_q   <= oor_q;
                  mem_data_q  <= oor_q ? ERR_DATA : mem_q[idx_q];
               end
            end
            ST_RESP: begin
               state_q     <= ST_IDLE;
               mem_ready_q <= 1'b0;
               mem_err_q   <= 1'b0;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q     <= ST_IDLE;
               mem_ready_q <= 1'b0;
               mem_err_q   <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign mem_data  = mem_data_q;
   assign mem_ready = mem_ready_q;
   assign mem_err   = mem_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder: the driver predicts each response from a word-array
// model when the request is issued; an independent monitor pops and compares on every mem_ready.
module tb_imem_responder;

   localparam int          LAT   = 4;
   localparam int          WORDS = 1024;
   localparam logic [31:0] ERRW  = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = 32'd0;
   logic [31:0] load_data = 32'd0;
   logic        busy;
   logic        mem_err;

   imem_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(WORDS), .LATENCY(LAT), .ERR_DATA(ERRW)
   ) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_ready(mem_ready), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .busy(busy), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [WORDS];

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          c;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic out_of_range(input logic [31:0] a);
`ifdef IMEM_ADDR_CHECK_EN
      return a[31:12] != 20'd0;
`else
      return 1'b0;
`endif
   endfunction

   // Monitor: every mem_ready pulse must match the oldest prediction in data, error flag and cycle.
   always @(negedge clk) begin
      if (!rst && mem_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got mem_ready=1 want 0 (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("resp_data",  mem_data, mon_e.d);
            chk("resp_err",   {31'd0, mem_err}, {31'd0, mon_e.e});
            chk("resp_cycle", 32'(cyc), 32'(mon_e.c));
         end
      end
   end

   // Caller is just past a negedge; writes one word through the load port.
   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      model[a[11:2]] = d;
      load_en = 1'b0;
   endtask

   // mode 0: random loads, 1: force load to the same word on the response edge,
   // 2: force load to the same word on the capture edge, 3: no loads.
   task automatic do_req(input logic [31:0] addr, input int mode);
      logic [9:0]  idx;
      logic [31:0] expd;
      logic        le [LAT];
      logic [31:0] la [LAT];
      logic [31:0] ld [LAT];
      exp_t        e;
      idx = addr[11:2];
      for (int j = 0; j < LAT; j++) begin
         le[j] = (mode == 0) && ($urandom_range(0, 2) == 0);
         ld[j] = $urandom;
         la[j] = $urandom;
         if ($urandom_range(0, 1) == 1) la[j][11:2] = idx;
      end
      if (mode == 1) begin
         le[LAT-1] = 1'b1;
         la[LAT-1] = {20'd0, idx, 2'b00};
      end
      if (mode == 2) begin
         le[0] = 1'b1;
         la[0] = {20'd0, idx, 2'b01};
      end
      // Loads on edges before the response edge are visible; the response-edge load is not.
      expd = model[idx];
      for (int j = 0; j < LAT - 1; j++)
         if (le[j] && la[j][11:2] == idx) expd = ld[j];
      if (out_of_range(addr)) expd = ERRW;
      e.d = expd;
      e.e = out_of_range(addr);
      e.c = cyc + LAT;
      sb.push_back(e);
      for (int j = 0; j < LAT; j++)
         if (le[j]) model[la[j][11:2]] = ld[j];
      for (int j = 0; j < LAT; j++) begin
         mem_req   = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         mem_addr  = (j == 0) ? addr : $urandom;
         load_en   = le[j];
         load_addr = la[j];
         load_data = ld[j];
         @(negedge clk);
         chk("busy_inflight", {31'd0, busy}, 32'd1);
      end
      load_en  = 1'b0;
      mem_req  = 1'($urandom_range(0, 1));
      mem_addr = $urandom;
      @(negedge clk);
      chk("busy_after", {31'd0, busy}, 32'd0);
      mem_req = 1'b0;
   endtask

   logic [31:0] ra;
   logic [31:0] saved;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, mem_ready}, 32'd0);
      chk("rst_data",  mem_data, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_err",   {31'd0, mem_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < WORDS; i++) load_word(32'(i * 4), $urandom);

      load_word(32'h100, 32'hA5A5_0001);
      do_req(32'h100, 3);
      load_word(32'h100, 32'h1234_5678);
      do_req(32'h103, 3);
      load_word(32'h100, 32'h0000_0001);
      do_req(32'h100, 1);
      do_req(32'h100, 3);
      do_req(32'h200, 2);
      load_word(32'h0, 32'h0BAD_F00D);
      do_req(32'h1000, 3);
      do_req(32'h0, 3);

      // Reset mid-request: no pulse, outputs cleared, and a load during reset is discarded.
      saved    = model[10'h40];
      mem_req  = 1'b1;
      mem_addr = 32'h100;
      @(negedge clk);
      mem_req = 1'b0;
      @(negedge clk);
      rst       = 1'b1;
      load_en   = 1'b1;
      load_addr = 32'h100;
      load_data = ~saved;
      #1;
      chk("midrst_busy",  {31'd0, busy}, 32'd0);
      chk("midrst_ready", {31'd0, mem_ready}, 32'd0);
      chk("midrst_data",  mem_data, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("inrst_ready", {31'd0, mem_ready}, 32'd0);
      end
      rst     = 1'b0;
      load_en = 1'b0;
      repeat (6) @(negedge clk);
      do_req(32'h100, 3);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 3) == 0) ra = $urandom;
         else ra = {20'd0, 10'($urandom), 2'($urandom)};
         do_req(ra, $urandom_range(0, 3));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      repeat (8) @(negedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
